// File: rtl/sram_rr_ctrl.sv
// Two-requester round-robin front end for a single-port synchronous SRAM.
// Each grant becomes one strobe cycle, an optional read wait, and a one-cycle ack.
module sram_rr_ctrl #(
    parameter int unsigned AW     = 3,
    parameter int unsigned DW     = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_din,
    output logic          sram_we,
    output logic          sram_rd,
    input  logic [DW-1:0] sram_dout,
    output logic          busy
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e        state_q;
    logic          last_b_q;
    logic          gnt_b_q;
    logic          we_q;
    logic [CW-1:0] cnt_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic [DW-1:0] a_rdata_q;
    logic [DW-1:0] b_rdata_q;
    logic [AW-1:0] sram_addr_q;
    logic [DW-1:0] sram_din_q;
    logic          sram_we_q;
    logic          sram_rd_q;
    logic          busy_q;

    logic          any_req;
    logic          pick_b;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // B wins only when A is idle or A was served last.
    always_comb begin
        any_req   = a_req | b_req;
        pick_b    = b_req & (~a_req | ~last_b_q);
        win_we    = a_we;
        win_addr  = a_addr;
        win_wdata = a_wdata;
        if (pick_b) begin
            win_we    = b_we;
            win_addr  = b_addr;
            win_wdata = b_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_b_q    <= 1'b1;
            gnt_b_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            sram_addr_q <= '0;
            sram_din_q  <= '0;
            sram_we_q   <= 1'b0;
            sram_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            sram_we_q <= 1'b0;
            sram_rd_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_b_q     <= pick_b;
                        last_b_q    <= pick_b;
                        we_q        <= win_we;
                        sram_addr_q <= win_addr;
                        // Strobe is launched here so it is visible for exactly the ACCESS cycle.
                        if (win_we) begin
                            sram_we_q  <= 1'b1;
                            sram_din_q <= win_wdata;
                        end else begin
                            sram_rd_q  <= 1'b1;
                        end
                        busy_q  <= 1'b1;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (we_q) begin
                        a_ack_q <= ~gnt_b_q;
                        b_ack_q <= gnt_b_q;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q   <= CW'(RD_LAT);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (gnt_b_q) begin
                            b_rdata_q <= sram_dout;
                        end else begin
                            a_rdata_q <= sram_dout;
                        end
                        a_ack_q <= ~gnt_b_q;
                        b_ack_q <= gnt_b_q;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign sram_addr = sram_addr_q;
    assign sram_din  = sram_din_q;
    assign sram_we   = sram_we_q;
    assign sram_rd   = sram_rd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sram_rr_ctrl.sv
// Directed bench for sram_rr_ctrl: behavioural SRAMs, ack scoreboard, strobe monitors.
// A second instance built with RD_LAT=3 covers the longer read wait.
module tb_sram_rr_ctrl;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_ack, b_ack, sram_we, sram_rd, busy;
    logic [DW-1:0] a_rdata, b_rdata, sram_din, sram_dout;
    logic [AW-1:0] sram_addr;

    logic          c_a_req = 1'b0, c_a_we = 1'b0, c_b_req = 1'b0, c_b_we = 1'b0;
    logic [AW-1:0] c_a_addr = '0, c_b_addr = '0;
    logic [DW-1:0] c_a_wdata = '0, c_b_wdata = '0;
    logic          c_a_ack, c_b_ack, c_sram_we, c_sram_rd, c_busy;
    logic [DW-1:0] c_a_rdata, c_b_rdata, c_sram_din, c_sram_dout;
    logic [AW-1:0] c_sram_addr;

    sram_rr_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_we(sram_we),
        .sram_rd(sram_rd), .sram_dout(sram_dout), .busy(busy)
    );

    sram_rr_ctrl #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_req(c_a_req), .a_we(c_a_we), .a_addr(c_a_addr), .a_wdata(c_a_wdata),
        .a_ack(c_a_ack), .a_rdata(c_a_rdata),
        .b_req(c_b_req), .b_we(c_b_we), .b_addr(c_b_addr), .b_wdata(c_b_wdata),
        .b_ack(c_b_ack), .b_rdata(c_b_rdata),
        .sram_addr(c_sram_addr), .sram_din(c_sram_din), .sram_we(c_sram_we),
        .sram_rd(c_sram_rd), .sram_dout(c_sram_dout), .busy(c_busy)
    );

    // SRAM models: dout valid RD_LAT cycles after the RD strobe, unknown otherwise.
    logic [DW-1:0] mem  [8];
    logic [DW-1:0] mem3 [8];
    logic [DW-1:0] pipe3[3];

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= sram_rd ? mem[sram_addr] : 'x;
    end

    always @(posedge clk) begin
        if (c_sram_we) mem3[c_sram_addr] <= c_sram_din;
        pipe3[0] <= c_sram_rd ? mem3[c_sram_addr] : 'x;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign c_sram_dout = pipe3[2];

    // Cycle counter and strobe/ack monitors.
    int cyc = 0;
    int we_cnt = 0, b_ack_cnt = 0, overlap = 0, c_rd_cnt = 0, c_rd_long = 0;
    logic c_prev_rd = 1'b0;
    int rd_cycles[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_we) we_cnt <= we_cnt + 1;
        if (sram_rd) rd_cycles.push_back(cyc);
        if (sram_we && sram_rd) overlap <= overlap + 1;
        if (b_ack) b_ack_cnt <= b_ack_cnt + 1;
        if (c_sram_rd) c_rd_cnt <= c_rd_cnt + 1;
        if (c_sram_rd && c_prev_rd) c_rd_long <= c_rd_long + 1;
        c_prev_rd <= c_sram_rd;
    end

    typedef struct {
        logic          who_b;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sbq[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_busy"},    32'(busy),      32'd0);
        check({pfx, "_a_ack"},   32'(a_ack),     32'd0);
        check({pfx, "_b_ack"},   32'(b_ack),     32'd0);
        check({pfx, "_we"},      32'(sram_we),   32'd0);
        check({pfx, "_rd"},      32'(sram_rd),   32'd0);
        check({pfx, "_addr"},    32'(sram_addr), 32'd0);
        check({pfx, "_din"},     32'(sram_din),  32'd0);
        check({pfx, "_a_rdata"}, 32'(a_rdata),   32'd0);
        check({pfx, "_b_rdata"}, 32'(b_rdata),   32'd0);
    endtask

    task automatic push(input logic who_b, input logic [DW-1:0] data, input int due);
        exp_t e;
        e.who_b = who_b;
        e.data  = data;
        e.due   = due;
        sbq.push_back(e);
    endtask

    task automatic drive(input logic who_b, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        if (who_b) begin
            b_we = we; b_addr = addr; b_wdata = wd; b_req = 1'b1;
        end else begin
            a_we = we; a_addr = addr; a_wdata = wd; a_req = 1'b1;
        end
    endtask

    task automatic release_req(input logic who_b);
        @(posedge clk);
        #1;
        if (who_b) b_req = 1'b0;
        else       a_req = 1'b0;
    endtask

    // Wait (bounded) for the next ack and compare it with the oldest expectation.
    task automatic wait_ack();
        exp_t e;
        logic got;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = a_ack | b_ack;
        end
        check("ack_seen", 32'(got), 32'd1);
        if (!got) return;
        check("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() == 0) return;
        e = sbq.pop_front();
        check("ack_requester", 32'(b_ack), 32'(e.who_b));
        check("ack_exclusive", 32'(a_ack & b_ack), 32'd0);
        if (e.due >= 0) check("ack_cycle", 32'(cyc), 32'(e.due));
        check("rdata", 32'(e.who_b ? b_rdata : a_rdata), 32'(e.data));
    endtask

    int k, r0, wsnap, bsnap, crd0;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A writes FF to addr 0, then reads it back.
        wsnap = we_cnt; bsnap = b_ack_cnt;
        drive(1'b0, 1'b1, 3'd0, 8'hFF); push(1'b0, 8'h00, cyc + 2);
        wait_ack();
        release_req(1'b0);
        drive(1'b0, 1'b0, 3'd0, 8'h00); push(1'b0, 8'hFF, cyc + 3);
        wait_ack();
        check("t1_we_pulses", 32'(we_cnt - wsnap), 32'd1);
        check("t1_no_b_ack", 32'(b_ack_cnt - bsnap), 32'd0);
        release_req(1'b0);

        // Simultaneous writes straight out of reset: A first, then B.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd1, 8'h11); push(1'b0, 8'h00, cyc + 2);
        drive(1'b1, 1'b1, 3'd2, 8'h22); push(1'b1, 8'h00, cyc + 5);
        wait_ack();
        release_req(1'b0);
        wait_ack();
        release_req(1'b1);
        drive(1'b0, 1'b0, 3'd1, 8'h00); push(1'b0, 8'h11, cyc + 3);
        wait_ack();
        release_req(1'b0);
        drive(1'b1, 1'b0, 3'd2, 8'h00); push(1'b1, 8'h22, cyc + 3);
        wait_ack();
        release_req(1'b1);

        // Continuous contention: both reads held across four accesses.
        r0 = rd_cycles.size();
        k  = cyc;
        drive(1'b0, 1'b0, 3'd1, 8'h00);
        drive(1'b1, 1'b0, 3'd2, 8'h00);
        push(1'b0, 8'h11, k + 3);
        push(1'b1, 8'h22, k + 7);
        push(1'b0, 8'h11, k + 11);
        push(1'b1, 8'h22, k + 15);
        repeat (4) wait_ack();
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        check("t3_rd_count", 32'(rd_cycles.size() - r0), 32'd4);
        for (int i = r0 + 1; i < rd_cycles.size(); i++)
            check("t3_rd_gap", 32'(rd_cycles[i] - rd_cycles[i-1] >= 4), 32'd1);

        // Reset while a B read sits in WAIT; B keeps requesting, A joins at release.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 3'd2, 8'h00);
        repeat (3) @(negedge clk);
        check("t4_wait_busy", 32'(busy), 32'd1);
        check("t4_wait_rd", 32'(sram_rd), 32'd0);
        check("t4_wait_addr", 32'(sram_addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        bsnap = b_ack_cnt;
        @(negedge clk);
        check("t4_no_b_ack", 32'(b_ack_cnt - bsnap), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'd1, 8'h00);
        push(1'b0, 8'h11, cyc + 3);
        push(1'b1, 8'h22, cyc + 7);
        wait_ack();
        release_req(1'b0);
        wait_ack();
        release_req(1'b1);

        // Held req: A stays high the cycle after ack and gets a second access.
        @(posedge clk); #1;
        k = cyc;
        drive(1'b0, 1'b0, 3'd0, 8'h00);
        push(1'b0, 8'hFF, k + 3);
        push(1'b0, 8'hFF, k + 7);
        wait_ack();
        repeat (2) @(negedge clk);
        check("t5_busy_access", 32'(busy), 32'd1);
        check("t5_rd_access", 32'(sram_rd), 32'd1);
        check("t5_addr_access", 32'(sram_addr), 32'd0);
        wait_ack();
        release_req(1'b0);
        @(negedge clk);
        check("t5_busy_after", 32'(busy), 32'd0);
        @(negedge clk);
        check("t5_idle_after", 32'(busy), 32'd0);
        check("t5_no_third_ack", 32'(a_ack), 32'd0);
        check("never_we_and_rd", 32'(overlap), 32'd0);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        // RD_LAT=3 instance: write A5 to addr 5, then read it.
        @(posedge clk); #1;
        c_a_we = 1'b1; c_a_addr = 3'd5; c_a_wdata = 8'hA5; c_a_req = 1'b1;
        k = cyc;
        for (int n = 0; n < 20 && !c_a_ack; n++) @(negedge clk);
        check("c_wr_ack_seen", 32'(c_a_ack), 32'd1);
        check("c_wr_ack_cycle", 32'(cyc), 32'(k + 2));
        @(posedge clk); #1;
        c_a_we = 1'b0;
        k = cyc; crd0 = c_rd_cnt;
        for (int n = 0; n < 20 && !c_a_ack; n++) @(negedge clk);
        check("c_rd_ack_seen", 32'(c_a_ack), 32'd1);
        check("c_rd_ack_cycle", 32'(cyc), 32'(k + 5));
        check("c_rd_rdata", 32'(c_a_rdata), 32'hA5);
        @(posedge clk); #1;
        c_a_req = 1'b0;
        repeat (2) @(negedge clk);
        check("c_rd_pulses", 32'(c_rd_cnt - crd0), 32'd1);
        check("c_rd_single", 32'(c_rd_long), 32'd0);
        check("c_idle", 32'(c_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_rr_ctrl.md
Name: sram_rr_ctrl

Overview:
- Two-requester round-robin controller sharing the single-port 8x8 SRAM (synchronous write and read, one RD/WE strobe per access).
- Arbitrates between requesters A and B and sequences each access as one SRAM strobe cycle, then an optional read-wait, then a response.
- Returns a one-cycle ack with read data to the winning requester.
- Sits between CPU-side masters and the SRAM instance and owns the SRAM strobe and address pins.

Parameters:
- AW, 3, SRAM address width (8 locations)
- DW, 8, SRAM data width
- RD_LAT, 1, cycles after the RD strobe before dataOut is valid; legal range 1..7

Ports:
- clk  in  1  system clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A access request; held until a_ack
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  AW  A address
- a_wdata  in  DW  A write data
- a_ack  out  1  A one-cycle completion pulse
- a_rdata  out  DW  A read data; valid when a_ack=1 after a read
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B
- sram_addr  out  AW  to SRAM Addr
- sram_din  out  DW  to SRAM dataIn
- sram_we  out  1  to SRAM WE
- sram_rd  out  1  to SRAM RD
- sram_dout  in  DW  from SRAM dataOut
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - All outputs 0: acks, rdata, sram_*, busy.
  - last_grant = B, so A wins the first tie.
  - Wait counter = 0.
- Reset mid-operation: the access in flight is abandoned and no ack is issued. A write already strobed may have landed in the SRAM.
- All outputs are registered.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - On grant: latch we, addr and wdata of the winner; update last_grant; go to ACCESS.
- ACCESS, exactly one cycle:
  - sram_addr = latched addr.
  - Write: sram_din = latched wdata, sram_we = 1, next state RESP.
  - Read: sram_rd = 1, load the wait counter with RD_LAT, next state WAIT.
- WAIT:
  - sram_we = 0 and sram_rd = 0; sram_addr is held.
  - The counter decrements each cycle.
  - When the counter reaches 1, capture sram_dout into the granted rdata register and go to RESP.
- RESP, one cycle:
  - The granted ack is 1; the other ack is 0.
  - The granted rdata holds the captured value. Rdata is unchanged after a write.
  - Next state IDLE.
- Strobes are 0 in every state other than ACCESS; sram_we and sram_rd are never high together.
- Latency, with req sampled high in IDLE at cycle 0:
  - Write: ACCESS at cycle 1, ack at cycle 2.
  - Read: ack at cycle 2+RD_LAT (cycle 3 by default).
- Requester rules:
  - Keep req, we, addr and wdata stable until ack.
  - Deassert req, or present a new request, in the cycle after ack.
  - In that cycle the controller is in IDLE, so a held req is treated as a new request.
- Requests that change while not granted are ignored until the next IDLE arbitration.
- rdata registers hold their value until that requester's next read completes.
- Fairness: with both reqs continuously high, grants alternate A, B, A, B...
- No starvation: worst-case wait = one full access of the other requester plus one IDLE cycle.

Test Plan:
- Single write then read:
  - A writes 8'hFF to addr 0, then reads addr 0.
  - Required: sram_we=1 for exactly one cycle, a_ack at cycle 2; read a_ack at cycle 3 with a_rdata=8'hFF; b_ack stays 0.
- Simultaneous requests from reset:
  - A writes 8'h11 to addr 1 while B writes 8'h22 to addr 2, both raised in the same cycle.
  - Required: A is granted first, B next; then reading addr 1 returns 8'h11 and addr 2 returns 8'h22.
- Continuous contention:
  - Both reqs held high across 4 reads.
  - Required: ack order A, B, A, B; sram_rd pulses are exactly one cycle each, with at least 3 cycles between strobes.
- RD_LAT=3 build:
  - A reads addr 5 previously written with 8'hA5.
  - Required: a_ack exactly 5 cycles after the IDLE sample, a_rdata=8'hA5, sram_rd high for one cycle only.
- Reset during WAIT:
  - Drop rst_n while a B read is in WAIT.
  - Required: all outputs 0 immediately, no b_ack, state IDLE.
  - Then, with B requesting again after reset release, A requests next: A wins the tie because last_grant has been reset to B.
- Held-req rule:
  - A keeps req high one cycle after ack.
  - Required: a second access to the same addr is issued and acked, and busy drops only after the final ack.
